// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and FSM encoding for the button debounce path
package debounce_pkg;

  localparam int DEF_CNT_W      = 6;
  localparam int DEF_STABLE_CNT = 40;

  localparam logic [1:0] ST_IDLE_LOW   = 2'b00;
  localparam logic [1:0] ST_CHECK_HIGH = 2'b01;
  localparam logic [1:0] ST_IDLE_HIGH  = 2'b10;
  localparam logic [1:0] ST_CHECK_LOW  = 2'b11;

  typedef enum logic [1:0] {
    IDLE_LOW   = ST_IDLE_LOW,
    CHECK_HIGH = ST_CHECK_HIGH,
    IDLE_HIGH  = ST_IDLE_HIGH,
    CHECK_LOW  = ST_CHECK_LOW
  } dbc_state_t;

endpackage

// File: rtl/debounce_ctrl_sync_2ff.sv
// rtl/debounce_ctrl_sync_2ff.sv - two-flop synchroniser, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/debounce_ctrl.sv
// rtl/debounce_ctrl.sv - debounce FSM driving an external stability counter
// DEBOUNCE_RELEASE_PULSE_EN enables the btn_release pulse register.
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_in,
  input  logic [CNT_W-1:0] time_counter,
  output logic             state,
  output logic             count_finished,
  output logic             btn_level,
  output logic             btn_press,
  output logic             btn_release
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(STABLE_CNT - 1);

  dbc_state_t r_state;
  dbc_state_t w_next;
  logic       w_sync;
  logic       w_thresh;
  logic       w_enable;
  logic       w_clear;
  logic       w_set_high;
  logic       w_set_low;
  logic       r_btn_level;
  logic       r_btn_press;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (btn_in),
    .q     (w_sync)
  );

  // >= so an overrun or wrapped counter still commits instead of stalling
  assign w_thresh = (time_counter >= THRESH);

  always_comb begin
    w_next     = r_state;
    w_enable   = 1'b0;
    w_clear    = 1'b0;
    w_set_high = 1'b0;
    w_set_low  = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (w_sync) w_next = CHECK_HIGH;
      end
      CHECK_HIGH: begin
        w_enable = 1'b1;
        if (!w_sync) begin
          w_clear = 1'b1;
          w_next  = IDLE_LOW;
        end else if (w_thresh) begin
          w_clear    = 1'b1;
          w_set_high = 1'b1;
          w_next     = IDLE_HIGH;
        end
      end
      IDLE_HIGH: begin
        if (!w_sync) w_next = CHECK_LOW;
      end
      CHECK_LOW: begin
        w_enable = 1'b1;
        if (w_sync) begin
          w_clear = 1'b1;
          w_next  = IDLE_HIGH;
        end else if (w_thresh) begin
          w_clear   = 1'b1;
          w_set_low = 1'b1;
          w_next    = IDLE_LOW;
        end
      end
      default: w_next = IDLE_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE_LOW;
      r_btn_level <= 1'b0;
      r_btn_press <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_btn_press <= w_set_high;
      if (w_set_high) begin
        r_btn_level <= 1'b1;
      end else if (w_set_low) begin
        r_btn_level <= 1'b0;
      end
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic r_btn_release;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_release <= 1'b0;
    end else begin
      r_btn_release <= w_set_low;
    end
  end

  assign btn_release = r_btn_release;
`else
  assign btn_release = 1'b0;
`endif

  assign state          = w_enable;
  assign count_finished = w_clear;
  assign btn_level      = r_btn_level;
  assign btn_press      = r_btn_press;

endmodule
